// File: rtl/wb_arbiter_pkg.sv
// Shared writeback definitions: ROB/data types, load-buffer entry and arbiter defaults.
`default_nettype none

package wb_arbiter_pkg;

  localparam int ROB_ID_WIDTH    = 6;
  localparam int WB_LD_BUF_DEPTH = 4;
  localparam int WB_STARVE_LIMIT = 3;

  typedef logic [31:0]             reg_data_t;
  typedef logic [ROB_ID_WIDTH-1:0] rob_id_t;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LD  = 1'b1
  } wb_src_t;

  typedef struct packed {
    rob_id_t   rob_id;
    reg_data_t data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_ld_buf.sv
// Circular FIFO of load results waiting for a free writeback slot.
`default_nettype none

module wb_ld_buf
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_LD_BUF_DEPTH
) (
  input  logic      clk,
  input  logic      rst_aL,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      empty,
  output logic      full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// Single-port writeback arbiter: ALU has priority, loads are buffered with starvation relief.
// Optional WB_LD_BYPASS_EN: an accepted load goes straight to writeback when the port is idle.
`default_nettype none

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int LD_BUF_DEPTH = WB_LD_BUF_DEPTH,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic                    clk,
  input  logic                    rst_aL,
  input  logic                    alu_result_valid,
  input  logic [ROB_ID_WIDTH-1:0] alu_result_rob_id,
  input  logic [31:0]             alu_result_data,
  input  logic                    ld_result_valid,
  output logic                    ld_result_ready,
  input  logic [ROB_ID_WIDTH-1:0] ld_result_rob_id,
  input  logic [31:0]             ld_result_data,
  output logic                    wb_valid,
  output logic [ROB_ID_WIDTH-1:0] wb_rob_id,
  output logic [31:0]             wb_data,
  output logic                    wb_src,
  output logic                    iiq_issue_hold
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  wb_entry_t        head;
  wb_entry_t        ld_entry;
  logic             empty;
  logic             full;
  logic             accept;
  logic             bypass;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] starve_cnt;
  wb_src_t          src;

  assign ld_entry        = '{rob_id: ld_result_rob_id, data: ld_result_data};
  assign ld_result_ready = rst_aL && !full;
  assign accept          = ld_result_valid && ld_result_ready;

`ifdef WB_LD_BYPASS_EN
  assign bypass = accept && empty && !alu_result_valid;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = rst_aL && !alu_result_valid && !empty;
  assign push = accept && !bypass;

  wb_ld_buf #(
    .DEPTH(LD_BUF_DEPTH)
  ) u_ld_buf (
    .clk       (clk),
    .rst_aL    (rst_aL),
    .push      (push),
    .push_entry(ld_entry),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .full      (full)
  );

  always_comb begin
    wb_valid  = 1'b0;
    wb_rob_id = '0;
    wb_data   = '0;
    src       = WB_SRC_ALU;
    if (!rst_aL) begin
      wb_valid = 1'b0;
    end else if (alu_result_valid) begin
      wb_valid  = 1'b1;
      wb_rob_id = alu_result_rob_id;
      wb_data   = alu_result_data;
    end else if (!empty) begin
      wb_valid  = 1'b1;
      wb_rob_id = head.rob_id;
      wb_data   = head.data;
      src       = WB_SRC_LD;
    end else if (bypass) begin
      wb_valid  = 1'b1;
      wb_rob_id = ld_result_rob_id;
      wb_data   = ld_result_data;
      src       = WB_SRC_LD;
    end
  end

  assign wb_src = src;

  // Reaching the limit raises the hold for one cycle and restarts the count,
  // so the ALU goes quiet the cycle after and the buffer head drains.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      starve_cnt     <= '0;
      iiq_issue_hold <= 1'b0;
    end else begin
      iiq_issue_hold <= (starve_cnt == STARVE_MAX);
      if (pop || empty || (starve_cnt == STARVE_MAX)) begin
        starve_cnt <= '0;
      end else if (alu_result_valid) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed vectors, per-source expectation queues.
`default_nettype none

module tb_wb_arbiter;

  logic        clk;
  logic        rst_aL;
  logic        alu_result_valid;
  logic [5:0]  alu_result_rob_id;
  logic [31:0] alu_result_data;
  logic        ld_result_valid;
  logic        ld_result_ready;
  logic [5:0]  ld_result_rob_id;
  logic [31:0] ld_result_data;
  logic        wb_valid;
  logic [5:0]  wb_rob_id;
  logic [31:0] wb_data;
  logic        wb_src;
  logic        iiq_issue_hold;

  int errors = 0;
  int checks = 0;

  logic [37:0] alu_q [$];
  logic [37:0] ld_q  [$];
  logic [37:0] mon_exp;

  wb_arbiter #(
    .LD_BUF_DEPTH(4),
    .STARVE_LIMIT(3)
  ) dut (
    .clk              (clk),
    .rst_aL           (rst_aL),
    .alu_result_valid (alu_result_valid),
    .alu_result_rob_id(alu_result_rob_id),
    .alu_result_data  (alu_result_data),
    .ld_result_valid  (ld_result_valid),
    .ld_result_ready  (ld_result_ready),
    .ld_result_rob_id (ld_result_rob_id),
    .ld_result_data   (ld_result_data),
    .wb_valid         (wb_valid),
    .wb_rob_id        (wb_rob_id),
    .wb_data          (wb_data),
    .wb_src           (wb_src),
    .iiq_issue_hold   (iiq_issue_hold)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [5:0] aid, input logic [31:0] ad,
                       input logic lv, input logic [5:0] lid, input logic [31:0] ldd);
    alu_result_valid  = av;
    alu_result_rob_id = aid;
    alu_result_data   = ad;
    ld_result_valid   = lv;
    ld_result_rob_id  = lid;
    ld_result_data    = ldd;
    #1;
    if (av) alu_q.push_back({aid, ad});
    if (lv && ld_result_ready) ld_q.push_back({lid, ldd});
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every writeback is matched against the queue for its source.
  always @(negedge clk) begin
    if (rst_aL) begin
      if (wb_valid) begin
        checks++;
        if (wb_src == 1'b0) begin
          if (alu_q.size() == 0) begin
            errors++;
            $display("FAIL wb_alu_extra: got rob %0d data 0x%0h, expected no ALU writeback", wb_rob_id, wb_data);
          end else begin
            mon_exp = alu_q.pop_front();
            if ({wb_rob_id, wb_data} !== mon_exp) begin
              errors++;
              $display("FAIL wb_alu: got 0x%0h expected 0x%0h", {wb_rob_id, wb_data}, mon_exp);
            end
          end
        end else begin
          if (ld_q.size() == 0) begin
            errors++;
            $display("FAIL wb_ld_extra: got rob %0d data 0x%0h, expected no load writeback", wb_rob_id, wb_data);
          end else begin
            mon_exp = ld_q.pop_front();
            if ({wb_rob_id, wb_data} !== mon_exp) begin
              errors++;
              $display("FAIL wb_ld: got 0x%0h expected 0x%0h", {wb_rob_id, wb_data}, mon_exp);
            end
          end
        end
      end else begin
        chk("wb_idle_zero", 64'({wb_rob_id, wb_data, wb_src}), 64'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_aL = 1'b0;
    alu_result_valid = 1'b0; alu_result_rob_id = '0; alu_result_data = '0;
    ld_result_valid  = 1'b0; ld_result_rob_id  = '0; ld_result_data  = '0;
    #2;
    chk("reset_wb_valid", 64'(wb_valid), 64'd0);
    chk("reset_ready",    64'(ld_result_ready), 64'd0);
    chk("reset_hold",     64'(iiq_issue_hold), 64'd0);
    tick();
    rst_aL = 1'b1;
    #1;
    chk("post_reset_ready", 64'(ld_result_ready), 64'd1);
    tick();

    // ALU and load in the same cycle, empty buffer
    drive(1'b1, 6'd5, 32'h11, 1'b1, 6'd7, 32'h22);
    chk("t1_alu_valid", 64'(wb_valid), 64'd1);
    chk("t1_alu_rob",   64'(wb_rob_id), 64'd5);
    chk("t1_alu_src",   64'(wb_src), 64'd0);
    tick();
    idle();
    chk("t1_ld_rob", 64'(wb_rob_id), 64'd7);
    chk("t1_ld_src", 64'(wb_src), 64'd1);
    tick();

    // Four loads under continuous ALU fill the buffer
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 6'(10 + i), 32'h100 + 32'(i), 1'b1, 6'(20 + i), 32'h200 + 32'(i));
      chk("t2_ready_while_filling", 64'(ld_result_ready), 64'd1);
      tick();
    end
    idle();
    chk("t2_ready_full", 64'(ld_result_ready), 64'd0);
    tick();
    idle();
    chk("t2_ready_after_pop", 64'(ld_result_ready), 64'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("t2_all_loads_drained", 64'(ld_q.size()), 64'd0);

    // Starvation: one buffered load with the ALU busy every cycle
    drive(1'b1, 6'd40, 32'h400, 1'b1, 6'd30, 32'h300);
    tick();
    for (int i = 1; i < 5; i++) begin
      drive(1'b1, 6'(40 + i), 32'h400 + 32'(i), 1'b0, 6'd0, 32'h0);
      chk("t3_hold_low", 64'(iiq_issue_hold), 64'd0);
      tick();
    end
    drive(1'b1, 6'd45, 32'h405, 1'b0, 6'd0, 32'h0);
    chk("t3_hold_high", 64'(iiq_issue_hold), 64'd1);
    tick();
    idle();
    chk("t3_hold_one_cycle", 64'(iiq_issue_hold), 64'd0);
    chk("t3_ld_wb", 64'({wb_valid, wb_src, wb_rob_id}), {56'd0, 1'b1, 1'b1, 6'd30});
    tick();

    // Load into idle port: bypass timing depends on build option
    drive(1'b0, 6'd0, 32'h0, 1'b1, 6'd9, 32'h900);
`ifdef WB_LD_BYPASS_EN
    chk("t4_bypass_same_cycle", 64'({wb_valid, wb_src, wb_rob_id}), {56'd0, 1'b1, 1'b1, 6'd9});
    tick();
    idle();
    chk("t4_bypass_no_repeat", 64'(wb_valid), 64'd0);
`else
    chk("t4_no_bypass", 64'(wb_valid), 64'd0);
    tick();
    idle();
    chk("t4_next_cycle", 64'({wb_valid, wb_src, wb_rob_id}), {56'd0, 1'b1, 1'b1, 6'd9});
`endif
    tick();

    // Full buffer, then push and pop together so both pointers wrap
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 6'(50 + i), 32'h500 + 32'(i), 1'b1, 6'(60 + i), 32'h600 + 32'(i));
      tick();
    end
    drive(1'b0, 6'd0, 32'h0, 1'b1, 6'd63, 32'hdead);
    chk("t5_full_no_credit", 64'(ld_result_ready), 64'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 6'd0, 32'h0, 1'b1, 6'(64 + i), 32'h640 + 32'(i));
      chk("t5_push_pop_ready", 64'(ld_result_ready), 64'd1);
      tick();
    end
    drive(1'b1, 6'd54, 32'h504, 1'b1, 6'd67, 32'h643);
    tick();
    drive(1'b1, 6'd55, 32'h505, 1'b0, 6'd0, 32'h0);
    chk("t5_refilled_full", 64'(ld_result_ready), 64'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      idle();
      tick();
    end
    chk("t5_drained", 64'(ld_q.size()), 64'd0);

    // Reset with three loads buffered
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'(80 + i), 32'h800 + 32'(i), 1'b1, 6'(70 + i), 32'h700 + 32'(i));
      tick();
    end
    alu_result_valid = 1'b0;
    ld_result_valid  = 1'b0;
    rst_aL = 1'b0;
    #1;
    ld_q.delete();
    chk("t6_rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("t6_rst_hold",     64'(iiq_issue_hold), 64'd0);
    chk("t6_rst_ready",    64'(ld_result_ready), 64'd0);
    tick();
    tick();
    rst_aL = 1'b1;
    #1;
    chk("t6_ready_after_release", 64'(ld_result_ready), 64'd1);
    chk("t6_empty_after_release", 64'(wb_valid), 64'd0);
    tick();
    idle();
    chk("t6_still_empty", 64'(wb_valid), 64'd0);
    tick();
    tick();

    chk("end_alu_q_empty", 64'(alu_q.size()), 64'd0);
    chk("end_ld_q_empty",  64'(ld_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter LD_BUF_DEPTH, default 4, load-result buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 3, consecutive ALU-won cycles with a buffered load before an issue hold.
REQ-003 SHALL have port clk  in  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst_aL  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port alu_result_valid  in  1  ALU result this cycle; never backpressured.
REQ-006 SHALL have ports alu_result_rob_id  in  ROB_ID_WIDTH and alu_result_data  in  32 (reg_data_t), the ALU result.
REQ-007 SHALL have port ld_result_valid  in  1  load unit offers a result.
REQ-008 SHALL have port ld_result_ready  out  1  load result accepted when valid&&ready.
REQ-009 SHALL have ports ld_result_rob_id  in  ROB_ID_WIDTH and ld_result_data  in  32, the load result.
REQ-010 SHALL have port wb_valid  out  1  single writeback/broadcast port to ROB and regfile.
REQ-011 SHALL have ports wb_rob_id  out  ROB_ID_WIDTH, wb_data  out  32, wb_src  out  1 (0 = ALU, 1 = load).
REQ-012 SHALL have port iiq_issue_hold  out  1  registered; integer issue queue must not issue while high.

Function
REQ-013 SHALL drive wb from ALU, combinationally, whenever alu_result_valid=1 (ALU has absolute priority).
REQ-014 SHALL, when alu_result_valid=0 and buffer non-empty, drive wb from buffer head and pop it that cycle.
REQ-015 SHALL otherwise drive wb_valid=0, wb_rob_id/wb_data/wb_src = 0.
REQ-016 SHALL assert ld_result_ready = ~full, computed from current occupancy only (no same-cycle pop credit).
REQ-017 SHALL push an accepted load into the buffer tail (except under REQ-025); FIFO order is preserved.
REQ-018 SHALL allow simultaneous push and pop; occupancy unchanged; read and write pointers wrap modulo LD_BUF_DEPTH.
REQ-019 SHALL keep starve_cnt (width clog2(STARVE_LIMIT+1)): +1 when buffer non-empty and alu_result_valid=1; clear on any pop or when buffer empty; saturate at STARVE_LIMIT.
REQ-020 SHALL set iiq_issue_hold flop next cycle when starve_cnt reaches STARVE_LIMIT, and hold it exactly one cycle, then clear starve_cnt.
REQ-021 SHALL rely on contract: iiq_issue_hold=1 in cycle t guarantees alu_result_valid=0 in cycle t+1, so the head pops in t+1.
REQ-022 SHALL guarantee any buffered load writes back within STARVE_LIMIT+2 cycles of reaching the head.

Reset
REQ-023 SHALL, while rst_aL=0, asynchronously clear pointers, occupancy, starve_cnt, iiq_issue_hold; wb_valid=0, wb_src=0, ld_result_ready=0.
REQ-024 SHALL discard buffered loads on reset mid-operation; ld_result_ready=1 in the first cycle after rst_aL rises.

Configuration
REQ-025 SHALL, with WB_LD_BYPASS_EN defined, send an accepted load straight to wb (wb_src=1) in the same cycle when buffer empty and alu_result_valid=0, without pushing.
REQ-026 SHALL, without WB_LD_BYPASS_EN, push every accepted load; minimum load writeback latency 1 cycle.

Structure
REQ-027 SHALL place wb_entry_t {rob_id, data}, wb_src_t, WB_LD_BUF_DEPTH and WB_STARVE_LIMIT in the shared global defs package.
REQ-028 SHALL instantiate one sub-module, wb_ld_buf, a circular FIFO of wb_entry_t holding pointers and occupancy.

Verification
REQ-029 SHALL cover: alu valid rob 5 data 0x11, ld valid rob 7 data 0x22, empty buffer -> wb rob 5 src 0; rob 7 written next cycle src 1.
REQ-030 SHALL cover: 4 loads back-to-back under continuous ALU, depth 4 -> ready=0 after 4th accept; no load lost; FIFO order on drain.
REQ-031 SHALL cover: buffered load, ALU valid every cycle, STARVE_LIMIT 3 -> hold=1 in exactly one cycle; load written back the following cycle.
REQ-032 SHALL cover: bypass on, empty buffer, no ALU, ld rob 9 -> wb rob 9 same cycle; bypass off -> one cycle later.
REQ-033 SHALL cover: full buffer with push and pop same cycle -> occupancy stays 4, pointers wrap, order preserved.
REQ-034 SHALL cover: rst_aL low with 3 entries buffered -> wb_valid=0, hold=0 immediately; buffer empty and ready=1 after release.
